csr_file: RTL

- Machine-mode CSR storage for the multi-cycle npc core.
- Write side is the end of the write-back CSR path: the `csrdwen`/`csrdid`/`csrd` triple produced at write-back lands here.
- Read side is a combinational CSR read port for decode/execute, plus trap-entry and `mret` state updates and a free-running 64-bit cycle counter.
- Supplies the trap and return target PCs to the next-PC logic.

---
 rtl/csr_file.sv | 129 ++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/misa/mtvec/mscratch/mepc/mcause plus a 64-bit mcycle.
// Combinational read port; trap entry and mret take precedence over write-back CSR writes.
module csr_file #(
  parameter int                   DATA_W   = 32,
  parameter int                   ADDR_W   = 12,
  parameter logic [DATA_W-1:0]    MISA_VAL = 32'h4000_1100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_csrdwen,
  input  logic [ADDR_W-1:0] i_csrdid,
  input  logic [DATA_W-1:0] i_csrd,
  input  logic [ADDR_W-1:0] i_csrsid,
  output logic [DATA_W-1:0] o_csrs,
  output logic              o_illegal,
  input  logic              i_commit,
  input  logic              i_ecall,
  input  logic              i_mret,
  input  logic [DATA_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_trap_pc,
  output logic [DATA_W-1:0] o_mret_pc,
  output logic              o_mie
);

  localparam logic [ADDR_W-1:0] A_MSTATUS  = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MISA     = ADDR_W'(12'h301);
  localparam logic [ADDR_W-1:0] A_MTVEC    = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] A_MSCRATCH = ADDR_W'(12'h340);
  localparam logic [ADDR_W-1:0] A_MEPC     = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE   = ADDR_W'(12'h342);
  localparam logic [ADDR_W-1:0] A_MCYCLE   = ADDR_W'(12'hB00);
  localparam logic [ADDR_W-1:0] A_MCYCLEH  = ADDR_W'(12'hB80);

  localparam logic [DATA_W-1:0] ALIGN_MASK = ~(DATA_W'(3));
  localparam logic [DATA_W-1:0] CAUSE_ECALL_M = DATA_W'(11);

  logic                r_mie;
  logic                r_mpie;
  logic [DATA_W-1:0]   r_mtvec;
  logic [DATA_W-1:0]   r_mscratch;
  logic [DATA_W-1:0]   r_mepc;
  logic [DATA_W-1:0]   r_mcause;
  logic [2*DATA_W-1:0] r_mcycle;

  logic                w_trap;
  logic                w_mret;
  logic                w_sw_wr;
  logic [DATA_W-1:0]   w_mstatus;
  logic [DATA_W-1:0]   w_cyc_lo_inc;
  logic [2*DATA_W-1:0] w_mcycle_nxt;

  assign w_trap  = i_commit & i_ecall;
  assign w_mret  = i_commit & i_mret & ~i_ecall;
  assign w_sw_wr = i_csrdwen & ~w_trap & ~w_mret;

  // MPP is hardwired to M-mode; only MIE/MPIE are storage.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[3]     = r_mie;
    w_mstatus[7]     = r_mpie;
    w_mstatus[12:11] = 2'b11;
  end

  assign w_cyc_lo_inc = r_mcycle[DATA_W-1:0] + DATA_W'(1);

  always_comb begin
    w_mcycle_nxt = r_mcycle + (2*DATA_W)'(1);
    if (w_sw_wr && i_csrdid == A_MCYCLE)
      w_mcycle_nxt = {r_mcycle[2*DATA_W-1:DATA_W], i_csrd};
    else if (w_sw_wr && i_csrdid == A_MCYCLEH)
      w_mcycle_nxt = {i_csrd, w_cyc_lo_inc};
  end

  always_comb begin
    o_csrs    = '0;
    o_illegal = 1'b0;
    case (i_csrsid)
      A_MSTATUS:  o_csrs = w_mstatus;
      A_MISA:     o_csrs = MISA_VAL;
      A_MTVEC:    o_csrs = r_mtvec;
      A_MSCRATCH: o_csrs = r_mscratch;
      A_MEPC:     o_csrs = r_mepc;
      A_MCAUSE:   o_csrs = r_mcause;
      A_MCYCLE:   o_csrs = r_mcycle[DATA_W-1:0];
      A_MCYCLEH:  o_csrs = r_mcycle[2*DATA_W-1:DATA_W];
      default:    o_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
    end else begin
      r_mcycle <= w_mcycle_nxt;
      if (w_trap) begin
        r_mepc   <= i_pc & ALIGN_MASK;
        r_mcause <= CAUSE_ECALL_M;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (i_csrdwen) begin
        case (i_csrdid)
          A_MSTATUS: begin
            r_mie  <= i_csrd[3];
            r_mpie <= i_csrd[7];
          end
          A_MTVEC:    r_mtvec    <= i_csrd;
          A_MSCRATCH: r_mscratch <= i_csrd;
          A_MEPC:     r_mepc     <= i_csrd & ALIGN_MASK;
          A_MCAUSE:   r_mcause   <= i_csrd;
          default: ;
        endcase
      end
    end
  end

  assign o_trap_pc = r_mtvec & ALIGN_MASK;
  assign o_mret_pc = r_mepc;
  assign o_mie     = r_mie;

endmodule
